// File: rtl/muldiv_seq_pkg.sv
// Shared CPU package: FSM state encoding and op encodings for the
// sequential multiply/divide unit (also used by ctrl_unit).
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_seq_booth_step.sv
// booth_step: one combinational radix-2 Booth iteration.
// Ports:
//   acc      - upper partial-product accumulator (WIDTH+1 bits, signed)
//   q        - multiplier / lower product bits
//   q_1      - Booth guard bit (previous q[0])
//   m        - sign-extended multiplicand (WIDTH+1 bits)
//   acc_next, q_next, q_1_next - values after add/sub and arithmetic shift
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  // Arithmetic shift right across {acc, q, q_1}. The accumulator is one bit
  // wider than the operands so subtracting the most-negative multiplicand
  // cannot overflow.
  assign acc_next = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next   = {sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential signed multiply (radix-2 Booth) / signed divide
// (restoring, on magnitudes, with a sign-fix cycle).
// Ports:
//   clk, reset (async, active-low)
//   start, op (0 = multiply, 1 = divide), a, b - request and operands
//   hi_out / lo_out - product high/low, or remainder/quotient
//   busy - operation in progress; done - one-cycle completion pulse
//   div_zero - last divide had b == 0 (held until next accepted start)
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t state_reg, state_next;

  // acc_reg/q_reg hold the Booth partial product in MULT and the
  // remainder/quotient pair in DIV.
  logic [WIDTH:0]   acc_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q1_reg;
  logic [WIDTH:0]   m_reg;
  logic [CW-1:0]    cnt_reg;
  logic             a_neg_reg, quot_neg_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             div_zero_reg;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic             booth_q1;
  logic [WIDTH:0]   div_shift, div_diff, div_rem;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign accept    = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign last_iter = (cnt_reg == CW'(1));

  // Magnitudes are unsigned, so the most-negative value maps to 2^(WIDTH-1).
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  booth_step #(.WIDTH(WIDTH)) u_booth_step (
    .acc      (acc_reg),
    .q        (q_reg),
    .q_1      (q1_reg),
    .m        (m_reg),
    .acc_next (booth_acc),
    .q_next   (booth_q),
    .q_1_next (booth_q1)
  );

  // Restoring divide step: shift next dividend bit into the remainder and
  // keep the trial subtraction only if it did not go negative.
  always_comb begin
    div_shift = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    div_diff  = div_shift - m_reg;
    if (div_diff[WIDTH]) begin
      div_rem  = div_shift;
      div_quot = {q_reg[WIDTH-2:0], 1'b0};
    end else begin
      div_rem  = div_diff;
      div_quot = {q_reg[WIDTH-2:0], 1'b1};
    end
  end

  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign q_fix = quot_neg_reg ? -q_reg : q_reg;
  assign r_fix = a_neg_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        done = (state_reg == ST_DONE);
        if (start) begin
          if (op == OP_MULT)  state_next = ST_MULT;
          else if (b == '0)   state_next = ST_DONE;
          else                state_next = ST_DIV;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_MULT: begin
        busy = 1'b1;
        if (last_iter) state_next = ST_DONE;
      end
      ST_DIV: begin
        busy = 1'b1;
        if (last_iter) state_next = ST_FIX;
      end
      ST_FIX: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg      <= '0;
      q_reg        <= '0;
      q1_reg       <= 1'b0;
      m_reg        <= '0;
      cnt_reg      <= '0;
      a_neg_reg    <= 1'b0;
      quot_neg_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            div_zero_reg <= (op == OP_DIV) && (b == '0);
            cnt_reg      <= CW'(WIDTH);
            acc_reg      <= '0;
            q1_reg       <= 1'b0;
            a_neg_reg    <= a[WIDTH-1];
            quot_neg_reg <= a[WIDTH-1] ^ b[WIDTH-1];
            if (op == OP_MULT) begin
              q_reg <= a;
              m_reg <= {b[WIDTH-1], b};
            end else begin
              q_reg <= a_mag;
              m_reg <= {1'b0, b_mag};
            end
          end
        end
        ST_MULT: begin
          acc_reg <= booth_acc;
          q_reg   <= booth_q;
          q1_reg  <= booth_q1;
          cnt_reg <= cnt_reg - CW'(1);
          if (last_iter) begin
            hi_reg <= booth_acc[WIDTH-1:0];
            lo_reg <= booth_q;
          end
        end
        ST_DIV: begin
          acc_reg <= div_rem;
          q_reg   <= div_quot;
          cnt_reg <= cnt_reg - CW'(1);
        end
        ST_FIX: begin
          hi_reg <= r_fix;
          lo_reg <= q_fix;
        end
        default: ;
      endcase
    end
  end

  assign hi_out   = hi_reg;
  assign lo_out   = lo_reg;
  assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected results computed
// with plain 64-bit integer arithmetic; a monitor pops on every done pulse.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi_out, lo_out;
  logic         busy, done, div_zero;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           edge_n;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           last_n = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference model: called at a negedge; the request is accepted at the
  // next rising edge (edge N).
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx, sy, p, qt, rm;
    start = 1'b1; op = o; a = x; b = y;
    last_n = cyc + 1;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 1'b0) begin
      p = sx * sy;
      e.hi = p[63:32]; e.lo = p[31:0]; e.dz = 1'b0; e.edge_n = last_n + W + 1;
    end else if (y == '0) begin
      e.hi = last_hi; e.lo = last_lo; e.dz = 1'b1; e.edge_n = last_n + 1;
    end else begin
      qt = sx / sy;
      rm = sx % sy;
      e.hi = rm[31:0]; e.lo = qt[31:0]; e.dz = 1'b0; e.edge_n = last_n + W + 2;
    end
    last_hi = e.hi;
    last_lo = e.lo;
    exp_q.push_back(e);
    $display("issue op=%0d a=%08h b=%08h N=%0d exp hi=%08h lo=%08h dz=%0d",
             o, x, y, last_n, e.hi, e.lo, e.dz);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Wait (bounded) until done is visible at a negedge, for back-to-back issue.
  task automatic wait_done_neg();
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("wait_done_timeout", 64'(done), 64'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        $display("done at edge %0d: hi=%08h lo=%08h dz=%0d", cyc + 1, hi_out, lo_out, div_zero);
        chk("hi_out", 64'(hi_out), 64'(e.hi));
        chk("lo_out", 64'(lo_out), 64'(e.lo));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
        chk("done_edge", 64'(cyc + 1), 64'(e.edge_n));
      end
    end
    if (busy && done) chk("busy_and_done", 64'd1, 64'd0);
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_hi"}, 64'(hi_out), 64'd0);
    chk({tag, "_lo"}, 64'(lo_out), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_dz"}, 64'(div_zero), 64'd0);
  endtask

  initial begin
    logic         o;
    logic [W-1:0] x, y;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;

    // Accepted on the first edge after release
    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0007);
    @(negedge clk); start = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
    drain();

    issue(1'b0, 32'h8000_0000, 32'h8000_0000);
    @(negedge clk); start = 1'b0; drain();

    @(negedge clk); issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    @(negedge clk); start = 1'b0; drain();

    // Prior result hi=5, lo=9 (95 / 10), then divide by zero keeps it
    @(negedge clk); issue(1'b1, 32'd95, 32'd10);
    @(negedge clk); start = 1'b0; drain();
    @(negedge clk); issue(1'b1, 32'h1234_5678, 32'h0);
    @(negedge clk); start = 1'b0; drain();

    @(negedge clk); issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clk); start = 1'b0; drain();

    // Start pulsed while busy is ignored
    @(negedge clk); issue(1'b0, 32'h0001_2345, 32'hFFFF_F000);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0;
    @(negedge clk); start = 1'b0;
    drain();

    // Back-to-back: start held high in DONE, busy rises next cycle
    @(negedge clk); issue(1'b0, 32'h0000_0003, 32'hFFFF_FFFB);
    @(negedge clk); start = 1'b0;
    wait_done_neg();
    issue(1'b1, 32'h0000_0064, 32'hFFFF_FFF9);
    @(negedge clk); start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    drain();

    // Reset low mid-multiply after edge N+10: no done, outputs return to 0
    @(negedge clk); issue(1'b0, 32'h7654_3210, 32'h0BAD_F00D);
    @(negedge clk); start = 1'b0;
    while (cyc < last_n + 10) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    last_hi = '0; last_lo = '0;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    @(negedge clk); reset = 1'b1;
    repeat (40) @(negedge clk);
    check_outputs_zero("post_reset");

    // Randomized mix, some back-to-back
    for (int i = 0; i < 60; i++) begin
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = '0;
        1: x = 32'h8000_0000;
        2: y = 32'hFFFF_FFFF;
        3: y = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if (exp_q.size() != 0 && $urandom_range(0, 2) == 0) begin
        wait_done_neg();
      end else begin
        drain();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(o, x, y);
      @(negedge clk); start = 1'b0;
    end
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
